// File: rtl/voice_allocator.sv
// Round-robin note-to-voice scheduler with beat-based occupancy tracking.
// Define VOICE_ALLOC_STEAL_EN to let a full pool steal the voice closest to finishing.
module voice_allocator #(
   parameter int unsigned NUM_VOICES = 3,
   parameter int unsigned NOTE_W     = 6,
   parameter int unsigned DUR_W      = 6
) (
   input  logic                         clk_i,
   input  logic                         reset_i,
   input  logic                         flush_i,
   input  logic                         beat_i,
   input  logic                         req_valid_i,
   input  logic [NOTE_W-1:0]            req_note_i,
   input  logic [DUR_W-1:0]             req_duration_i,
   output logic                         req_ready_o,
   output logic [NUM_VOICES-1:0]        load_note_o,
   output logic [NUM_VOICES*NOTE_W-1:0] note_out_o,
   output logic [NUM_VOICES*DUR_W-1:0]  duration_out_o,
   output logic [NUM_VOICES-1:0]        voice_busy_o,
   output logic [7:0]                   steal_count_o
);

   localparam int unsigned PtrW = $clog2(NUM_VOICES);
`ifdef VOICE_ALLOC_STEAL_EN
   localparam bit StealEn = 1'b1;
`else
   localparam bit StealEn = 1'b0;
`endif

   typedef enum logic {StIdle, StGrant} state_e;

   state_e                  state_q, state_d;
   logic [DUR_W-1:0]        remaining_q [NUM_VOICES];
   logic [PtrW-1:0]         rr_ptr_q, sel_q, free_idx, pick_idx;
   logic [PtrW:0]           scan_idx;
   logic [NOTE_W-1:0]       note_lat_q;
   logic [DUR_W-1:0]        dur_lat_q;
   logic [NUM_VOICES*NOTE_W-1:0] note_q;
   logic [NUM_VOICES*DUR_W-1:0]  dur_q;
   logic                    any_free, accept, alloc, grant;

   assign accept = req_valid_i && req_ready_o;
   assign alloc  = accept && (req_duration_i != '0);
   assign grant  = (state_q == StGrant) && !flush_i && !reset_i;
   assign note_out_o     = note_q;
   assign duration_out_o = dur_q;

   // A voice is busy exactly while it still has beats left to play.
   always_comb begin
      voice_busy_o = '0;
      for (int v = 0; v < NUM_VOICES; v++) voice_busy_o[v] = (remaining_q[v] != '0);
   end

   always_comb begin
      any_free = 1'b0;
      free_idx = '0;
      scan_idx = '0;
      for (int unsigned i = 0; i < NUM_VOICES; i++) begin
         scan_idx = {1'b0, rr_ptr_q} + (PtrW+1)'(i);
         if (scan_idx >= (PtrW+1)'(NUM_VOICES)) scan_idx = scan_idx - (PtrW+1)'(NUM_VOICES);
         if (!any_free && !voice_busy_o[scan_idx[PtrW-1:0]]) begin
            any_free = 1'b1;
            free_idx = scan_idx[PtrW-1:0];
         end
      end
   end

`ifdef VOICE_ALLOC_STEAL_EN
   logic [PtrW-1:0]  victim_idx;
   logic [DUR_W-1:0] min_rem;
   logic             steal_pend_q;
   logic [7:0]       steal_cnt_q;

   // Strict less-than keeps the lowest index on a tie.
   always_comb begin
      victim_idx = '0;
      min_rem    = remaining_q[0];
      for (int i = 1; i < NUM_VOICES; i++) begin
         if (remaining_q[i] < min_rem) begin
            min_rem    = remaining_q[i];
            victim_idx = PtrW'(i);
         end
      end
   end

   assign pick_idx      = any_free ? free_idx : victim_idx;
   assign steal_count_o = steal_cnt_q;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         steal_pend_q <= 1'b0;
         steal_cnt_q  <= 8'd0;
      end else if (!flush_i) begin
         if (alloc) steal_pend_q <= !any_free;
         if (grant && steal_pend_q && (steal_cnt_q != 8'hFF)) steal_cnt_q <= steal_cnt_q + 8'd1;
      end
   end
`else
   assign pick_idx      = free_idx;
   assign steal_count_o = 8'd0;
`endif

   always_ff @(posedge clk_i) begin
      if (reset_i) state_q <= StIdle;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (flush_i) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle:  if (alloc) state_d = StGrant;
            StGrant: state_d = StIdle;
            default: state_d = StIdle;
         endcase
      end
   end

   always_comb begin
      req_ready_o = (state_q == StIdle) && !flush_i && !reset_i && (any_free || StealEn);
      load_note_o = '0;
      if (grant) load_note_o[sel_q] = 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         rr_ptr_q   <= '0;
         sel_q      <= '0;
         note_lat_q <= '0;
         dur_lat_q  <= '0;
         note_q     <= '0;
         dur_q      <= '0;
         for (int v = 0; v < NUM_VOICES; v++) remaining_q[v] <= '0;
      end else if (flush_i) begin
         rr_ptr_q <= '0;
         for (int v = 0; v < NUM_VOICES; v++) remaining_q[v] <= '0;
      end else begin
         if (alloc) begin
            sel_q      <= pick_idx;
            note_lat_q <= req_note_i;
            dur_lat_q  <= req_duration_i;
         end
         // The voice being loaded ignores a coincident beat.
         for (int v = 0; v < NUM_VOICES; v++) begin
            if (grant && (sel_q == PtrW'(v))) remaining_q[v] <= dur_lat_q;
            else if (beat_i && (remaining_q[v] != '0)) remaining_q[v] <= remaining_q[v] - 1'b1;
         end
         if (grant) begin
            note_q[int'(sel_q)*NOTE_W +: NOTE_W] <= note_lat_q;
            dur_q[int'(sel_q)*DUR_W +: DUR_W]    <= dur_lat_q;
            rr_ptr_q <= (sel_q == PtrW'(NUM_VOICES - 1)) ? '0 : sel_q + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator: expected load strobes are queued when a request
// is driven and popped when the strobe appears.
module tb_voice_allocator;

   localparam int NV = 3;
   localparam int NW = 6;
   localparam int DW = 6;

   logic          clk = 1'b0;
   logic          reset = 1'b0, flush = 1'b0, beat = 1'b0, req_valid = 1'b0;
   logic [NW-1:0] req_note = '0;
   logic [DW-1:0] req_duration = '0;
   logic          req_ready;
   logic [NV-1:0] load_note, voice_busy;
   logic [NV*NW-1:0] note_out;
   logic [NV*DW-1:0] duration_out;
   logic [7:0]    steal_count;

   typedef struct {
      logic [NV-1:0] oh;
      logic [NW-1:0] note;
      logic [DW-1:0] dur;
   } exp_t;

   exp_t sb[$];
   exp_t pend_e;
   bit   have_pend = 0;
   bit   due = 0;
   int   total = 0;
   int   bad = 0;
   bit   a;

   voice_allocator #(.NUM_VOICES(NV), .NOTE_W(NW), .DUR_W(DW)) dut (
      .clk_i(clk), .reset_i(reset), .flush_i(flush), .beat_i(beat),
      .req_valid_i(req_valid), .req_note_i(req_note), .req_duration_i(req_duration),
      .req_ready_o(req_ready), .load_note_o(load_note), .note_out_o(note_out),
      .duration_out_o(duration_out), .voice_busy_o(voice_busy), .steal_count_o(steal_count)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // One clock: observe accept/strobe late in the cycle, then step past the edge.
   task automatic tick(output bit acc);
      bit due_next;
      int vi;
      @(negedge clk);
      #3;
      acc = req_valid && req_ready;
      if (load_note != '0) begin
         if (sb.size() == 0) begin
            chk("unexpected_load", load_note, 0);
         end else begin
            pend_e = sb.pop_front();
            have_pend = 1;
            chk("load_onehot", load_note, pend_e.oh);
         end
      end else if (due) begin
         chk("strobe_latency", 0, 1);
         if (sb.size() != 0) void'(sb.pop_front());
      end
      due_next = acc && (req_duration != '0) && (sb.size() > 0);
      @(posedge clk);
      #1;
      due = due_next;
      if (have_pend) begin
         vi = 0;
         for (int i = 0; i < NV; i++) if (pend_e.oh[i]) vi = i;
         chk("note_slice", note_out[vi*NW +: NW], pend_e.note);
         chk("dur_slice", duration_out[vi*DW +: DW], pend_e.dur);
         have_pend = 0;
      end
   endtask

   task automatic do_reset();
      bit x;
      reset = 1'b1;
      tick(x);
      tick(x);
      reset = 1'b0;
      due = 0;
      #1;
   endtask

   task automatic send(input logic [NW-1:0] n, input logic [DW-1:0] d, input int voice,
                       input bit push);
      exp_t e;
      bit acc = 0;
      req_valid = 1'b1;
      req_note = n;
      req_duration = d;
      if (push) begin
         e.oh = NV'(1) << voice;
         e.note = n;
         e.dur = d;
         sb.push_back(e);
      end
      for (int k = 0; k < 20; k++) begin
         tick(acc);
         if (acc) break;
      end
      req_valid = 1'b0;
      chk("accept", acc, 1);
   endtask

   initial begin
      // Reset state
      do_reset();
      chk("rst_busy", voice_busy, 0);
      chk("rst_load", load_note, 0);
      chk("rst_note", note_out, 0);
      chk("rst_dur", duration_out, 0);
      chk("rst_steal", steal_count, 0);
      chk("rst_ready", req_ready, 1);

      // Three requests fill the pool in round-robin order
      send(6'd10, 6'd4, 0, 1);
      send(6'd20, 6'd4, 1, 1);
      send(6'd30, 6'd4, 2, 1);
      tick(a);
      chk("t1_busy", voice_busy, 3'b111);

      // Short note expires on the second beat; rr_ptr then points past voice 0
      do_reset();
      send(6'd5, 6'd2, 0, 1);
      tick(a);
      chk("t2_busy_a", voice_busy, 3'b001);
      beat = 1'b1; tick(a); beat = 1'b0;
      chk("t2_busy_b", voice_busy, 3'b001);
      beat = 1'b1; tick(a); beat = 1'b0;
      chk("t2_busy_c", voice_busy, 3'b000);
      send(6'd7, 6'd3, 1, 1);
      tick(a);
      chk("t2_busy_d", voice_busy, 3'b010);

`ifdef VOICE_ALLOC_STEAL_EN
      // Full pool steals the voice with least time left
      do_reset();
      send(6'd1, 6'd5, 0, 1);
      send(6'd2, 6'd2, 1, 1);
      send(6'd3, 6'd2, 2, 1);
      tick(a);
      chk("t4_busy", voice_busy, 3'b111);
      chk("t4_ready", req_ready, 1);
      send(6'd4, 6'd3, 1, 1);
      tick(a);
      chk("t4_steal", steal_count, 1);
      chk("t4_busy2", voice_busy, 3'b111);
`else
      // Full pool stalls until a beat frees voice 1
      do_reset();
      send(6'd1, 6'd4, 0, 1);
      send(6'd2, 6'd1, 1, 1);
      send(6'd3, 6'd4, 2, 1);
      begin
         exp_t e;
         e.oh = 3'b010; e.note = 6'd40; e.dur = 6'd3;
         sb.push_back(e);
      end
      req_valid = 1'b1; req_note = 6'd40; req_duration = 6'd3;
      for (int k = 0; k < 5; k++) begin
         tick(a);
         chk("t3_hold", a, 0);
      end
      chk("t3_ready", req_ready, 0);
      chk("t3_steal", steal_count, 0);
      beat = 1'b1; tick(a); beat = 1'b0;
      chk("t3_beat_cycle", a, 0);
      tick(a);
      chk("t3_accept", a, 1);
      req_valid = 1'b0;
      tick(a);
      chk("t3_busy", voice_busy, 3'b111);
`endif

      // Flush in the GRANT cycle cancels the strobe and resets rr_ptr
      do_reset();
      send(6'd9, 6'd3, 0, 1);
      tick(a);
      send(6'd11, 6'd3, 1, 0);
      flush = 1'b1;
      tick(a);
      flush = 1'b0;
      chk("t5_busy", voice_busy, 3'b000);
      chk("t5_note_held", note_out[0 +: NW], 6'd9);
      chk("t5_note_v1", note_out[NW +: NW], 6'd0);
      send(6'd12, 6'd2, 0, 1);
      tick(a);
      chk("t5_busy2", voice_busy, 3'b001);

      // Rest is consumed without a strobe and leaves the FSM idle
      send(6'd13, 6'd0, 1, 0);
      tick(a);
      chk("t6_busy", voice_busy, 3'b001);
      chk("t6_ready", req_ready, 1);
      tick(a);
      chk("t6_note_v1", note_out[NW +: NW], 6'd0);

      chk("sb_empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
